// File: rtl/osd_text_writer_pkg.sv
// Shared definitions for the OSD text writer: opcodes, FSM states,
// screen geometry and the Apple-text character encoder.
package osd_text_writer_pkg;

    // Command opcodes presented on cmd_op.
    typedef enum logic [1:0] {
        OSD_OP_CHAR    = 2'd0,
        OSD_OP_NEWLINE = 2'd1,
        OSD_OP_CLEAR   = 2'd2,
        OSD_OP_GOTO    = 2'd3
    } osd_op_e;

    // Writer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_SCREEN = 2'd1,
        ST_CLR_LINE   = 2'd2
    } osd_state_e;

    localparam int          OSD_COLS       = 40;
    localparam int          OSD_ROWS       = 24;
    localparam logic [7:0]  OSD_BLANK_CHAR = 8'hA0;

    // Apple-text encoding: lower case folds onto upper case, normal video
    // sets bit 7, inverse video keeps only the low six bits.
    function automatic logic [7:0] encode_char(input logic [6:0] c, input logic inverse);
        logic [6:0] folded;
        folded = c;
        if (c[6:5] == 2'b11) begin
            folded[5] = 1'b0;
        end
        return inverse ? {2'b00, folded[5:0]} : {1'b1, folded};
    endfunction

endpackage

// File: rtl/osd_text_writer_addr_map.sv
// Interleaved 40x24 text address map, identical to the one used by the
// video path: addr = row[2:0]*128 + row[4:3]*40 + col.
module osd_text_writer_addr_map (
    input  logic [4:0] row,
    input  logic [5:0] col,
    output logic [9:0] addr
);

    // Pure combinational address equation.
    always_comb begin
        addr = {row[2:0], 7'd0} + (10'(row[4:3]) * 10'd40) + 10'(col);
    end

endmodule

// File: rtl/osd_text_writer.sv
// Writer side of the OSD screen RAM: accepts character/cursor commands,
// writes encoded bytes into RAM port A, and runs clear-screen and
// clear-line sweeps with their own counters so the cursor is left alone.
module osd_text_writer
    import osd_text_writer_pkg::*;
#(
    parameter int         COLS           = OSD_COLS,
    parameter int         ROWS           = OSD_ROWS,
    parameter logic [7:0] BLANK_CHAR     = OSD_BLANK_CHAR,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [6:0] cmd_char,
    input  logic       cmd_inverse,
    input  logic [4:0] cmd_row,
    input  logic [5:0] cmd_col,
    output logic [9:0] OSDScrAddr,
    output logic [7:0] OSDScrData,
    output logic       OSDScrWe,
    output logic [4:0] cursor_row,
    output logic [5:0] cursor_col
);

    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [5:0] COL_LIMIT = 6'(COLS);
    localparam logic [4:0] ROW_LIMIT = 5'(ROWS);
    localparam osd_state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLR_SCREEN : ST_IDLE;

    osd_state_e state, state_next;
    osd_op_e    op;
    logic       accept;
    logic       at_last_cell;
    logic [4:0] sweep_row;
    logic [5:0] sweep_col;
    logic [4:0] map_row;
    logic [5:0] map_col;
    logic [9:0] map_addr;

    assign op           = osd_op_e'(cmd_op);
    assign cmd_ready    = rst_n && (state == ST_IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign at_last_cell = (cursor_row == LAST_ROW) && (cursor_col == LAST_COL);

    // One address map serves both paths: the cursor while idle, the sweep otherwise.
    assign map_row = (state == ST_IDLE) ? cursor_row : sweep_row;
    assign map_col = (state == ST_IDLE) ? cursor_col : sweep_col;

    osd_text_writer_addr_map u_addr_map (
        .row  (map_row),
        .col  (map_col),
        .addr (map_addr)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    // Next-state logic: commands only start sweeps from IDLE; sweeps end on their last cell.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OSD_OP_CHAR:    if (at_last_cell) state_next = ST_CLR_LINE;
                        OSD_OP_NEWLINE: if (cursor_row == LAST_ROW) state_next = ST_CLR_LINE;
                        OSD_OP_CLEAR:   state_next = ST_CLR_SCREEN;
                        OSD_OP_GOTO:    state_next = ST_IDLE;
                        default:        state_next = ST_IDLE;
                    endcase
                end
            end
            ST_CLR_SCREEN: begin
                if (sweep_row == LAST_ROW && sweep_col == LAST_COL) state_next = ST_IDLE;
            end
            ST_CLR_LINE: begin
                if (sweep_col == LAST_COL) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: cursor, sweep counters and the registered RAM port A outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_row <= '0;
            cursor_col <= '0;
            sweep_row  <= '0;
            sweep_col  <= '0;
            OSDScrAddr <= '0;
            OSDScrData <= BLANK_CHAR;
            OSDScrWe   <= 1'b0;
        end else begin
            // Address/data hold the last written pair when idle; only the strobe drops.
            OSDScrWe <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (op)
                            OSD_OP_CHAR: begin
                                OSDScrAddr <= map_addr;
                                OSDScrData <= encode_char(cmd_char, cmd_inverse);
                                OSDScrWe   <= 1'b1;
                                if (cursor_col != LAST_COL) begin
                                    cursor_col <= cursor_col + 6'd1;
                                end else begin
                                    cursor_col <= '0;
                                    sweep_col  <= '0;
                                    if (cursor_row != LAST_ROW) begin
                                        cursor_row <= cursor_row + 5'd1;
                                    end else begin
                                        // Bottom-right wrap: back to the top and blank row 0.
                                        cursor_row <= '0;
                                        sweep_row  <= '0;
                                    end
                                end
                            end
                            OSD_OP_NEWLINE: begin
                                cursor_col <= '0;
                                sweep_col  <= '0;
                                if (cursor_row != LAST_ROW) begin
                                    cursor_row <= cursor_row + 5'd1;
                                end else begin
                                    cursor_row <= '0;
                                    sweep_row  <= '0;
                                end
                            end
                            OSD_OP_CLEAR: begin
                                sweep_row <= '0;
                                sweep_col <= '0;
                            end
                            OSD_OP_GOTO: begin
                                // Out-of-range targets are consumed without moving the cursor.
                                if (cmd_row < ROW_LIMIT && cmd_col < COL_LIMIT) begin
                                    cursor_row <= cmd_row;
                                    cursor_col <= cmd_col;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLR_SCREEN: begin
                    OSDScrAddr <= map_addr;
                    OSDScrData <= BLANK_CHAR;
                    OSDScrWe   <= 1'b1;
                    if (sweep_col != LAST_COL) begin
                        sweep_col <= sweep_col + 6'd1;
                    end else begin
                        sweep_col <= '0;
                        if (sweep_row != LAST_ROW) begin
                            sweep_row <= sweep_row + 5'd1;
                        end else begin
                            sweep_row  <= '0;
                            cursor_row <= '0;
                            cursor_col <= '0;
                        end
                    end
                end
                ST_CLR_LINE: begin
                    OSDScrAddr <= map_addr;
                    OSDScrData <= BLANK_CHAR;
                    OSDScrWe   <= 1'b1;
                    sweep_col  <= (sweep_col != LAST_COL) ? sweep_col + 6'd1 : 6'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_text_writer.sv
// Self-checking bench for osd_text_writer: table of single commands plus
// hand-written sequences for reset sweep, line wrap, held CLEAR and mid-sweep reset.
module tb_osd_text_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [6:0] cmd_char = '0;
    logic       cmd_inverse = 1'b0;
    logic [4:0] cmd_row = '0;
    logic [5:0] cmd_col = '0;
    logic [9:0] OSDScrAddr;
    logic [7:0] OSDScrData;
    logic       OSDScrWe;
    logic [4:0] cursor_row;
    logic [5:0] cursor_col;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] OP_CHAR = 2'd0, OP_NL = 2'd1, OP_CLR = 2'd2, OP_GOTO = 2'd3;

    always #5 clk = ~clk;

    osd_text_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_char    (cmd_char),
        .cmd_inverse (cmd_inverse),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .OSDScrAddr  (OSDScrAddr),
        .OSDScrData  (OSDScrData),
        .OSDScrWe    (OSDScrWe),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col)
    );

    typedef struct {
        logic [1:0] op;
        logic [6:0] ch;
        logic       inv;
        logic [4:0] row;
        logic [5:0] col;
        logic       we;
        logic [9:0] addr;
        logic [7:0] data;
        logic [4:0] crow;
        logic [5:0] ccol;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int tb_addr(input int r, input int c);
        return (r % 8) * 128 + (r / 8) * 40 + c;
    endfunction

    // Present a command, wait (bounded) for acceptance, return at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [6:0] ch, input logic inv,
                         input logic [4:0] row, input logic [5:0] col, input bit keep_valid);
        int waited = 0;
        @(negedge clk);
        cmd_op = op; cmd_char = ch; cmd_inverse = inv; cmd_row = row; cmd_col = col;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
        end
        @(negedge clk);
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    // Follow a sweep until cmd_ready rises, checking each write against the expected address sequence.
    task automatic watch_sweep(input int n_exp, input bit full, input int row, input int exp_low, input string tag);
        int writes = 0, bad = 0, holes = 0, low = 0, exp_a;
        bit done = 1'b0;
        for (int i = 0; i < n_exp + 100 && !done; i++) begin
            @(negedge clk);
            if (OSDScrWe) begin
                exp_a = full ? tb_addr(writes / 40, writes % 40) : tb_addr(row, writes);
                if (OSDScrAddr !== 10'(exp_a) || OSDScrData !== 8'hA0) bad++;
                if ((OSDScrAddr % 128) >= 120) holes++;
                writes++;
            end
            if (cmd_ready) done = 1'b1;
            else low++;
        end
        check({tag, "_done"},   32'(done),   32'd1);
        check({tag, "_writes"}, 32'(writes), 32'(n_exp));
        check({tag, "_badwr"},  32'(bad),    32'd0);
        check({tag, "_holes"},  32'(holes),  32'd0);
        check({tag, "_lowcyc"}, 32'(low),    32'(exp_low));
    endtask

    initial begin
        vecs[0]  = '{OP_CHAR, 7'h41, 1'b0, 5'd0,  6'd0,  1'b1, 10'd0,   8'hC1, 5'd0, 6'd1};
        vecs[1]  = '{OP_CHAR, 7'h41, 1'b1, 5'd0,  6'd0,  1'b1, 10'd1,   8'h01, 5'd0, 6'd2};
        vecs[2]  = '{OP_CHAR, 7'h61, 1'b0, 5'd0,  6'd0,  1'b1, 10'd2,   8'hC1, 5'd0, 6'd3};
        vecs[3]  = '{OP_GOTO, 7'h00, 1'b0, 5'd8,  6'd5,  1'b0, 10'd2,   8'hC1, 5'd8, 6'd5};
        vecs[4]  = '{OP_CHAR, 7'h5A, 1'b0, 5'd0,  6'd0,  1'b1, 10'd45,  8'hDA, 5'd8, 6'd6};
        vecs[5]  = '{OP_GOTO, 7'h00, 1'b0, 5'd24, 6'd0,  1'b0, 10'd45,  8'hDA, 5'd8, 6'd6};
        vecs[6]  = '{OP_GOTO, 7'h00, 1'b0, 5'd5,  6'd40, 1'b0, 10'd45,  8'hDA, 5'd8, 6'd6};
        vecs[7]  = '{OP_GOTO, 7'h00, 1'b0, 5'd7,  6'd12, 1'b0, 10'd45,  8'hDA, 5'd7, 6'd12};
        vecs[8]  = '{OP_NL,   7'h00, 1'b0, 5'd0,  6'd0,  1'b0, 10'd45,  8'hDA, 5'd8, 6'd0};
        vecs[9]  = '{OP_CHAR, 7'h7A, 1'b1, 5'd0,  6'd0,  1'b1, 10'd40,  8'h1A, 5'd8, 6'd1};
        vecs[10] = '{OP_GOTO, 7'h00, 1'b0, 5'd3,  6'd39, 1'b0, 10'd40,  8'h1A, 5'd3, 6'd39};
        vecs[11] = '{OP_CHAR, 7'h3F, 1'b0, 5'd0,  6'd0,  1'b1, 10'd423, 8'hBF, 5'd4, 6'd0};
        vecs[12] = '{OP_CHAR, 7'h40, 1'b0, 5'd0,  6'd0,  1'b1, 10'd512, 8'hC0, 5'd4, 6'd1};

        // Reset values and cmd_ready low while in reset.
        #23;
        check("rst_ready", 32'(cmd_ready),  32'd0);
        check("rst_we",    32'(OSDScrWe),   32'd0);
        check("rst_addr",  32'(OSDScrAddr), 32'd0);
        check("rst_data",  32'(OSDScrData), 32'hA0);
        check("rst_crow",  32'(cursor_row), 32'd0);
        check("rst_ccol",  32'(cursor_col), 32'd0);

        // Power-on clear: 960 blank writes, then idle.
        @(negedge clk);
        rst_n = 1'b1;
        watch_sweep(960, 1'b1, 0, 959, "por_clear");
        check("por_last_addr", 32'(OSDScrAddr), 32'd1015);
        @(negedge clk);
        check("por_we_after", 32'(OSDScrWe), 32'd0);

        // Single-command vectors.
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].ch, vecs[i].inv, vecs[i].row, vecs[i].col, 1'b0);
            check($sformatf("v%0d_we",    i), 32'(OSDScrWe),   32'(vecs[i].we));
            check($sformatf("v%0d_addr",  i), 32'(OSDScrAddr), 32'(vecs[i].addr));
            check($sformatf("v%0d_data",  i), 32'(OSDScrData), 32'(vecs[i].data));
            check($sformatf("v%0d_crow",  i), 32'(cursor_row), 32'(vecs[i].crow));
            check($sformatf("v%0d_ccol",  i), 32'(cursor_col), 32'(vecs[i].ccol));
            check($sformatf("v%0d_ready", i), 32'(cmd_ready),  32'd1);
        end

        // Bottom-right CHAR wraps to 0/0 and blanks row 0.
        issue(OP_GOTO, 7'h00, 1'b0, 5'd23, 6'd39, 1'b0);
        issue(OP_CHAR, 7'h42, 1'b0, 5'd0, 6'd0, 1'b0);
        check("wrap_we",    32'(OSDScrWe),   32'd1);
        check("wrap_addr",  32'(OSDScrAddr), 32'd1015);
        check("wrap_data",  32'(OSDScrData), 32'hC2);
        check("wrap_ready", 32'(cmd_ready),  32'd0);
        check("wrap_crow",  32'(cursor_row), 32'd0);
        watch_sweep(40, 1'b0, 0, 39, "wrap_line");
        check("wrap_ccol",  32'(cursor_col), 32'd0);

        // NEWLINE on the last row also wraps and blanks row 0.
        issue(OP_GOTO, 7'h00, 1'b0, 5'd23, 6'd5, 1'b0);
        issue(OP_NL, 7'h00, 1'b0, 5'd0, 6'd0, 1'b0);
        check("nl23_we",   32'(OSDScrWe),   32'd0);
        check("nl23_crow", 32'(cursor_row), 32'd0);
        check("nl23_ccol", 32'(cursor_col), 32'd0);
        watch_sweep(40, 1'b0, 0, 39, "nl23_line");

        // CLEAR with cmd_valid held: the next command waits for the full sweep.
        issue(OP_GOTO, 7'h00, 1'b0, 5'd10, 6'd10, 1'b0);
        issue(OP_CLR, 7'h00, 1'b0, 5'd0, 6'd0, 1'b1);
        check("clr_ready", 32'(cmd_ready), 32'd0);
        cmd_op = OP_GOTO; cmd_row = 5'd2; cmd_col = 6'd2;
        watch_sweep(960, 1'b1, 0, 959, "cmd_clear");
        check("clr_crow", 32'(cursor_row), 32'd0);
        check("clr_ccol", 32'(cursor_col), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_goto_crow", 32'(cursor_row), 32'd2);
        check("held_goto_ccol", 32'(cursor_col), 32'd2);

        // Reset in the middle of a clear sweep.
        issue(OP_CLR, 7'h00, 1'b0, 5'd0, 6'd0, 1'b0);
        repeat (500) @(negedge clk);
        check("mid_we_pre", 32'(OSDScrWe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we",    32'(OSDScrWe),   32'd0);
        check("mid_rst_addr",  32'(OSDScrAddr), 32'd0);
        check("mid_rst_data",  32'(OSDScrData), 32'hA0);
        check("mid_rst_crow",  32'(cursor_row), 32'd0);
        check("mid_rst_ccol",  32'(cursor_col), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_sweep(960, 1'b1, 0, 959, "restart_clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
